// File: rtl/ramio_cmd_pkg.sv
// ramio_cmd_pkg: shared opcodes, reply codes, RAMIO encodings and FSM states for the command master
package ramio_cmd_pkg;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam logic [1:0] WT_NONE = 2'b00;
  localparam logic [1:0] WT_BYTE = 2'b01;
  localparam logic [2:0] RT_NONE = 3'b000;
  localparam logic [2:0] RT_UBYTE = 3'b001;
  // WCSUM/RCSUM are only reached when the checksum option is built in
  typedef enum logic [3:0] {
    IDLE, ADDR, LEN, WDATA, WREQ, WWAIT, RREQ, RWAIT, TXB, ACK, NAK, WCSUM, RCSUM
  } state_t;
endpackage

// File: rtl/ramio_cmd_rx_hold.sv
// ramio_cmd_rx_hold: one-byte rx hold register that flags every byte it has to drop
module ramio_cmd_rx_hold (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       pop,
  input  logic       discard,
  output logic       full,
  output logic [7:0] data,
  output logic       drop
);
  logic take;
  assign take = rx_valid && !discard && (!full || pop);
  assign drop = rx_valid && !take;
  // a pop and a new byte in the same cycle refill the register, so nothing is lost
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (take) begin
      full <= 1'b1;
      data <= rx_data;
    end else if (pop) full <= 1'b0;
endmodule

// File: rtl/ramio_cmd_master.sv
// ramio_cmd_master: serial byte commands to RAMIO byte reads/writes; CMD_MASTER_CHECKSUM_EN adds XOR checksums
module ramio_cmd_master #(
  parameter int LenBitWidth = 16,
  parameter int TimeoutCycles = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        enable,
  output logic [1:0]  write_type,
  output logic [2:0]  read_type,
  output logic [31:0] address,
  output logic [31:0] data_in,
  input  logic [31:0] data_out,
  input  logic        data_out_ready,
  input  logic        busy,
  output logic        error
);
  import ramio_cmd_pkg::*;
  localparam int LenBytes = LenBitWidth / 8;
  localparam int TimerW = $clog2(TimeoutCycles + 2);
  state_t state;
  logic is_write;
  logic [3:0] byte_cnt;
  logic [31:0] addr;
  logic [LenBitWidth-1:0] len;
  logic [LenBitWidth-1:0] next_len;
  logic [TimerW-1:0] timer;
  logic timed_out;
  logic hold_full;
  logic hold_drop;
  logic [7:0] hold_data;
  logic pop;
  logic discard;
  logic unused_hi;
`ifdef CMD_MASTER_CHECKSUM_EN
  logic [7:0] csum;
`endif
  assign pop = hold_full && (state inside {IDLE, ADDR, LEN, WDATA, WCSUM});
  assign discard = state inside {RREQ, RWAIT, TXB, ACK, NAK, RCSUM};
  assign next_len = LenBitWidth'({len, hold_data});
  assign timed_out = timer == TimerW'(TimeoutCycles);
  assign unused_hi = ^data_out[31:8];

  ramio_cmd_rx_hold u_hold (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .pop(pop),
    .discard(discard),
    .full(hold_full),
    .data(hold_data),
    .drop(hold_drop)
  );

  // command sequencer; RAMIO strobes default low so every request lasts exactly one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      is_write <= 1'b0;
      byte_cnt <= '0;
      addr <= '0;
      len <= '0;
      timer <= '0;
      enable <= 1'b0;
      write_type <= WT_NONE;
      read_type <= RT_NONE;
      address <= '0;
      data_in <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      error <= 1'b0;
`ifdef CMD_MASTER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      error <= hold_drop;
      enable <= 1'b0;
      write_type <= WT_NONE;
      read_type <= RT_NONE;
      case (state)
        IDLE: if (hold_full) begin
          byte_cnt <= '0;
          is_write <= hold_data == OP_WRITE;
`ifdef CMD_MASTER_CHECKSUM_EN
          csum <= '0;
`endif
          if (hold_data == OP_WRITE || hold_data == OP_READ) state <= ADDR;
          else begin
            state <= NAK;
            tx_data <= NAK_BYTE;
            tx_valid <= 1'b1;
            error <= 1'b1;
          end
        end
        ADDR: if (hold_full) begin
          addr <= {addr[23:0], hold_data};
          byte_cnt <= byte_cnt == 4'd3 ? '0 : byte_cnt + 4'd1;
          if (byte_cnt == 4'd3) state <= LEN;
        end
        LEN: if (hold_full) begin
          len <= next_len;
          byte_cnt <= byte_cnt + 4'd1;
          if (byte_cnt == 4'(LenBytes - 1)) begin
            if (next_len == '0) begin
              state <= is_write ? ACK : IDLE;
              if (is_write) begin
                tx_data <= ACK_BYTE;
                tx_valid <= 1'b1;
              end
            end else if (is_write) state <= WDATA;
            else begin
              state <= RREQ;
              enable <= 1'b1;
              read_type <= RT_UBYTE;
              address <= addr;
            end
          end
        end
        WDATA: if (hold_full) begin
          state <= WREQ;
          enable <= 1'b1;
          write_type <= WT_BYTE;
          address <= addr;
          data_in <= {24'h0, hold_data};
`ifdef CMD_MASTER_CHECKSUM_EN
          csum <= csum ^ hold_data;
`endif
        end
        WREQ: begin
          state <= WWAIT;
          timer <= '0;
        end
        WWAIT: if (!busy) begin
          addr <= addr + 32'd1;
          len <= len - 1'b1;
          if (len == LenBitWidth'(1)) begin
`ifdef CMD_MASTER_CHECKSUM_EN
            state <= WCSUM;
`else
            state <= ACK;
            tx_data <= ACK_BYTE;
            tx_valid <= 1'b1;
`endif
          end else state <= WDATA;
        end else if (timed_out) begin
          state <= NAK;
          tx_data <= NAK_BYTE;
          tx_valid <= 1'b1;
          error <= 1'b1;
        end else timer <= timer + 1'b1;
        RREQ: begin
          state <= RWAIT;
          timer <= '0;
        end
        RWAIT: if (data_out_ready) begin
          state <= TXB;
          tx_data <= data_out[7:0];
          tx_valid <= 1'b1;
`ifdef CMD_MASTER_CHECKSUM_EN
          csum <= csum ^ data_out[7:0];
`endif
        end else if (timed_out) begin
          state <= NAK;
          tx_data <= NAK_BYTE;
          tx_valid <= 1'b1;
          error <= 1'b1;
        end else timer <= timer + 1'b1;
        TXB: if (tx_ready) begin
          tx_valid <= 1'b0;
          addr <= addr + 32'd1;
          len <= len - 1'b1;
          if (len == LenBitWidth'(1)) begin
`ifdef CMD_MASTER_CHECKSUM_EN
            state <= RCSUM;
            tx_data <= csum;
            tx_valid <= 1'b1;
`else
            state <= IDLE;
`endif
          end else begin
            state <= RREQ;
            enable <= 1'b1;
            read_type <= RT_UBYTE;
            address <= addr + 32'd1;
          end
        end
        ACK, NAK, RCSUM: if (tx_ready) begin
          tx_valid <= 1'b0;
          state <= IDLE;
        end
`ifdef CMD_MASTER_CHECKSUM_EN
        WCSUM: if (hold_full) begin
          state <= hold_data == csum ? ACK : NAK;
          tx_data <= hold_data == csum ? ACK_BYTE : NAK_BYTE;
          tx_valid <= 1'b1;
          if (hold_data != csum) error <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ramio_cmd_master.sv
// tb_ramio_cmd_master: directed and randomized command streams against a byte-level model of the protocol
module tb_ramio_cmd_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b1;
  logic enable;
  logic [1:0] write_type;
  logic [2:0] read_type;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out = 32'h0;
  logic data_out_ready = 1'b0;
  logic busy = 1'b0;
  logic error;

  int total = 0, passed = 0, failed = 0;
  int err_cnt = 0, bad_req = 0;
  int busy_cycles = 5, busy_left = 0, rd_lat = 1, rd_left = 0;
  int stall_at = 0, stall_n = 0;
  bit rnd_ready = 1'b0, stuck = 1'b0, prev_en = 1'b0;
  logic [31:0] rd_addr = 32'h0;
  logic [7:0] smem [logic [31:0]];
  logic [7:0] rmem [logic [31:0]];
  logic [7:0] txq[$], exp_tx[$], wdat[$];
  logic [63:0] wrq[$], exp_wr[$];

  ramio_cmd_master dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .enable(enable), .write_type(write_type), .read_type(read_type),
    .address(address), .data_in(data_in), .data_out(data_out),
    .data_out_ready(data_out_ready), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] rd_s(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] rd_r(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  // RAMIO slave: byte memory, busy after each write, read data after rd_lat cycles
  always @(negedge clk) begin
    logic [31:0] junk;
    junk = $urandom;
    data_out_ready = 1'b0;
    data_out = junk;
    if (rd_left > 0) begin
      rd_left--;
      if (rd_left == 0) begin
        data_out = {junk[31:8], rd_s(rd_addr)};
        data_out_ready = 1'b1;
      end
    end
    if (busy_left > 0) busy_left--;
    if (enable && write_type == 2'b01) begin
      wrq.push_back({address, data_in});
      smem[address] = data_in[7:0];
      busy_left = busy_cycles;
    end
    if (enable && read_type == 3'b001) begin
      rd_addr = address;
      rd_left = rd_lat;
    end
    busy = stuck || busy_left > 0;
  end

  // tx consumer, error pulse counter and request-shape monitor
  always @(negedge clk) begin
    if (stall_n > 0 && tx_valid && txq.size() == stall_at) begin
      tx_ready = 1'b0;
      stall_n--;
    end else tx_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (error) err_cnt++;
    if (enable && (prev_en || !({write_type, read_type} inside {5'b01000, 5'b00001}))) bad_req++;
    if (!enable && {write_type, read_type} != 5'b0) bad_req++;
    prev_en = enable;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [31:0] a, input int n);
    logic [15:0] n16;
    n16 = 16'(n);
    send(op, 0);
    for (int i = 3; i >= 0; i--) send(a[8*i +: 8], 0);
    send(n16[15:8], 0);
    send(n16[7:0], 0);
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int k = 0; k < budget && txq.size() < n; k++) @(negedge clk);
  endtask

  task automatic check_out_zero(input string tag);
    check({tag, "_addr_data"}, {address, data_in}, 64'h0);
    check({tag, "_ctl"}, {48'h0, tx_data, tx_valid, enable, write_type, read_type, error}, 64'h0);
  endtask

  // one command end to end; expectations come from the byte-level protocol model
  task automatic run_cmd(input bit w, input logic [31:0] a, input int n, input bit corrupt, input bit stray);
    logic [7:0] x, d;
    logic [31:0] ai;
    int e0, nerr;
    x = 8'h00;
    e0 = err_cnt;
    nerr = 0;
    txq.delete(); wrq.delete(); exp_tx.delete(); exp_wr.delete();
    send_hdr(w ? 8'h57 : 8'h52, a, n);
    if (!w && stray) begin
      repeat (2) @(negedge clk);
      send(8'h55, 0);
    end
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      if (w) begin
        d = wdat[i];
        rmem[ai] = d;
        exp_wr.push_back({ai, 24'h0, d});
        send(d, busy_cycles + 5);
      end else begin
        d = rd_r(ai);
        exp_tx.push_back(d);
      end
      x ^= d;
    end
`ifdef CMD_MASTER_CHECKSUM_EN
    if (n > 0) begin
      if (w) send(corrupt ? 8'h00 : x, 0);
      else exp_tx.push_back(x);
    end
    if (w && n > 0 && corrupt && x != 8'h00) nerr = 1;
`else
    if (corrupt) x = 8'h00;
`endif
    if (w) exp_tx.push_back(nerr != 0 ? 8'h15 : 8'h06);
    nerr += int'(!w && stray);
    wait_tx(exp_tx.size(), 3000);
    repeat (4) @(negedge clk);
    check("tx_count", 64'(txq.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++)
      check("tx_byte", {56'h0, i < txq.size() ? txq[i] : 8'bx}, {56'h0, exp_tx[i]});
    check("wr_count", 64'(wrq.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      check("wr_req", i < wrq.size() ? wrq[i] : 64'bx, exp_wr[i]);
    check("err_pulses", 64'(err_cnt - e0), 64'(nerr));
  endtask

  initial begin
    int e0, k;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    check_out_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    wdat = '{8'hAB};
    run_cmd(1'b1, 32'h0000_0011, 1, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h0000_0011, 1, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      smem[32'h10 + 32'(i)] = 8'h00;
      rmem[32'h10 + 32'(i)] = 8'h00;
    end
    smem[32'h10] = 8'hC4; smem[32'h11] = 8'hA9; smem[32'h12] = 8'hB8; smem[32'h13] = 8'hD5;
    rmem[32'h10] = 8'hC4; rmem[32'h11] = 8'hA9; rmem[32'h12] = 8'hB8; rmem[32'h13] = 8'hD5;
    stall_at = 1;
    stall_n = 3;
    run_cmd(1'b0, 32'h0000_0010, 4, 1'b0, 1'b0);
    check("stall_applied", 64'(stall_n), 64'h0);

    wdat = '{8'h01, 8'h02};
    run_cmd(1'b1, 32'hFFFF_FFFF, 2, 1'b0, 1'b0);

    txq.delete();
    e0 = err_cnt;
    send(8'h00, 0);
    wait_tx(1, 100);
    repeat (3) @(negedge clk);
    check("nak_count", 64'(txq.size()), 64'h1);
    check("nak_byte", {56'h0, txq.size() > 0 ? txq[0] : 8'bx}, 64'h15);
    check("nak_err", 64'(err_cnt - e0), 64'h1);
    run_cmd(1'b0, 32'hFFFF_FFFF, 2, 1'b0, 1'b0);

    run_cmd(1'b1, 32'h0000_0500, 0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h0000_0500, 0, 1'b0, 1'b0);

    rd_lat = 3;
    rnd_ready = 1'b1;
    run_cmd(1'b0, 32'h0000_0010, 3, 1'b0, 1'b1);

    busy_cycles = 3;
    txq.delete(); wrq.delete();
    e0 = err_cnt;
    send_hdr(8'h57, 32'h0000_0600, 2);
    send(8'h3A, 0);
    send(8'h5B, 0);
    send(8'h7C, 30);
`ifdef CMD_MASTER_CHECKSUM_EN
    send(8'h3A ^ 8'h5B, 0);
`endif
    rmem[32'h600] = 8'h3A;
    rmem[32'h601] = 8'h5B;
    wait_tx(1, 200);
    repeat (4) @(negedge clk);
    check("ovr_tx", {56'h0, txq.size() > 0 ? txq[0] : 8'bx}, 64'h06);
    check("ovr_wr_count", 64'(wrq.size()), 64'h2);
    check("ovr_wr1", wrq.size() > 1 ? wrq[1] : 64'bx, {32'h601, 32'h5B});
    check("ovr_err", 64'(err_cnt - e0), 64'h1);

`ifdef CMD_MASTER_CHECKSUM_EN
    wdat = '{8'h12, 8'h34};
    run_cmd(1'b1, 32'h0000_0700, 2, 1'b0, 1'b0);
    run_cmd(1'b1, 32'h0000_0700, 2, 1'b1, 1'b0);
`endif

    for (int t = 0; t < 16; t++) begin
      a = ($urandom_range(0, 1) != 0 ? 32'hFFFF_FFFC : 32'h0000_0100) + 32'($urandom_range(0, 7));
      busy_cycles = $urandom_range(0, 4);
      rd_lat = $urandom_range(1, 3);
      wdat.delete();
      for (int i = 0; i < 6; i++) wdat.push_back(8'($urandom));
      run_cmd($urandom_range(0, 1) != 0, a, $urandom_range(0, 5), 1'b0, 1'b0);
    end

    rnd_ready = 1'b0;
    stuck = 1'b1;
    txq.delete();
    e0 = err_cnt;
    send_hdr(8'h57, 32'h0000_0800, 1);
    send(8'h77, 0);
    rmem[32'h800] = 8'h77;
    k = 0;
    while (k < 6000 && txq.size() < 1) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("to_byte", {56'h0, txq.size() > 0 ? txq[0] : 8'bx}, 64'h15);
    check("to_err", 64'(err_cnt - e0), 64'h1);
    check("to_not_early", 64'(k > 4096 && k < 4200), 64'h1);

    wrq.delete();
    send_hdr(8'h57, 32'h0000_2000, 1);
    send(8'h3C, 0);
    rmem[32'h2000] = 8'h3C;
    for (int j = 0; j < 50 && wrq.size() == 0; j++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("pre_rst_addr", {32'h0, address}, 64'h2000);
    rst_n = 1'b0;
    #1;
    check_out_zero("rst_wwait");
    @(negedge clk);
    stuck = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    busy_cycles = 2;
    rd_lat = 1;
    run_cmd(1'b0, 32'h0000_2000, 1, 1'b0, 1'b0);
    check("req_shape", 64'(bad_req), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
